// File: rtl/uart_core.sv
// rtl/uart_core.sv - full-duplex UART with configurable frame, RX glitch filter, error flags and loopback
module uart_core #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    input  logic                 loopback,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 tx_busy,
    output logic                 rx_busy
);

    localparam int              CW         = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]      DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]      STOP_LAST  = 4'(STOP_BITS - 1);
    localparam bit              HAS_PARITY = (PARITY != 0);
    localparam bit              ODD        = (PARITY == 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                 tx_state;
    logic [CW-1:0]          tx_cnt;
    logic [3:0]             tx_bit;
    logic [DATA_BITS-1:0]   tx_shift;
    logic                   tx_par;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (tx_valid) begin
                        tx_shift <= tx_data;
                        tx_par   <= (^tx_data) ^ ODD;
                        tx_cnt   <= '0;
                        tx       <= 1'b0;
                        tx_ready <= 1'b0;
                        tx_busy  <= 1'b1;
                        tx_state <= ST_START;
                    end
                end
                default: begin
                    if (tx_cnt != BIT_LAST) begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end else begin
                        tx_cnt <= '0;
                        case (tx_state)
                            ST_START: begin
                                tx       <= tx_shift[0];
                                tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
                                tx_bit   <= '0;
                                tx_state <= ST_DATA;
                            end
                            ST_DATA: begin
                                if (tx_bit == DATA_LAST) begin
                                    tx_bit <= '0;
                                    if (HAS_PARITY) begin
                                        tx       <= tx_par;
                                        tx_state <= ST_PARITY;
                                    end else begin
                                        tx       <= 1'b1;
                                        tx_state <= ST_STOP;
                                    end
                                end else begin
                                    tx       <= tx_shift[0];
                                    tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
                                    tx_bit   <= tx_bit + 4'd1;
                                end
                            end
                            ST_PARITY: begin
                                tx       <= 1'b1;
                                tx_bit   <= '0;
                                tx_state <= ST_STOP;
                            end
                            default: begin
                                if (tx_bit == STOP_LAST) begin
                                    tx_ready <= 1'b1;
                                    tx_busy  <= 1'b0;
                                    tx_state <= ST_IDLE;
                                end else begin
                                    tx_bit <= tx_bit + 4'd1;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    logic                   line_in;
    logic                   sync1;
    logic                   sync2;
    logic                   armed;
    state_t                 rx_state;
    logic [CW-1:0]          rx_cnt;
    logic [3:0]             rx_bit;
    logic [DATA_BITS-1:0]   rx_shift;
    logic                   rx_pbit;
    logic                   rx_ferr;

    assign line_in = loopback ? tx : rx;

    // armed only rises after the line reads high, so a stuck-low line cannot retrigger a frame
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            armed      <= 1'b0;
            rx_state   <= ST_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_pbit    <= 1'b0;
            rx_ferr    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            sync1    <= line_in;
            sync2    <= sync1;
            rx_valid <= 1'b0;
            case (rx_state)
                ST_IDLE: begin
                    if (!armed) begin
                        armed <= sync2;
                    end else if (!sync2) begin
                        armed    <= 1'b0;
                        rx_cnt   <= '0;
                        rx_busy  <= 1'b1;
                        rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (rx_cnt != HALF_LAST) begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end else begin
                        rx_cnt <= '0;
                        if (!sync2) begin
                            rx_bit   <= '0;
                            rx_ferr  <= 1'b0;
                            rx_state <= ST_DATA;
                        end else begin
                            rx_busy  <= 1'b0;
                            rx_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    if (rx_cnt != BIT_LAST) begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end else begin
                        rx_cnt <= '0;
                        case (rx_state)
                            ST_DATA: begin
                                rx_shift <= {sync2, rx_shift[DATA_BITS-1:1]};
                                if (rx_bit == DATA_LAST) begin
                                    rx_bit   <= '0;
                                    rx_state <= HAS_PARITY ? ST_PARITY : ST_STOP;
                                end else begin
                                    rx_bit <= rx_bit + 4'd1;
                                end
                            end
                            ST_PARITY: begin
                                rx_pbit  <= sync2;
                                rx_state <= ST_STOP;
                            end
                            default: begin
                                if (rx_bit == STOP_LAST) begin
                                    rx_data    <= rx_shift;
                                    rx_valid   <= 1'b1;
                                    parity_err <= HAS_PARITY && ((^{rx_shift, rx_pbit}) ^ ODD);
                                    frame_err  <= rx_ferr | ~sync2;
                                    rx_busy    <= 1'b0;
                                    rx_state   <= ST_IDLE;
                                end else begin
                                    rx_ferr <= rx_ferr | ~sync2;
                                    rx_bit  <= rx_bit + 4'd1;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
